updown_mod_counter: RTL and testbench



---
 rtl/updown_mod_counter_if.sv | 25 ++
 rtl/updown_mod_counter.sv | 86 ++++++++
 tb/tb_updown_mod_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter: count controls in, count/flags out.
// No valid/ready: every rising clk edge is one transaction, and inputs are sampled at that edge.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             clr_ovf;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, load, din, clr_ovf,
    input  out, tc, wrap, ovf
  );

  modport slave (
    input  en, up, load, din, clr_ovf,
    output out, tc, wrap, ovf
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX+1) counter with load, terminal count, wrap pulse and sticky overflow.
// Define UPDOWN_MOD_COUNTER_SAT_EN for saturating mode (holds at the limits, wrap tied low).
module updown_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_val;
  logic             at_top;
  logic             at_bot;
  logic             tc;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             ovf_r;
  logic             ovf_set;

  assign at_top   = (count == MAX_V);
  assign at_bot   = (count == '0);
  assign tc       = bus.en & ~bus.load & ((bus.up & at_top) | (~bus.up & at_bot));
  assign load_val = (bus.din > MAX_V) ? MAX_V : bus.din;

  // tc is exactly "a count is attempted at the limit": a wrap event, or a
  // blocked attempt in saturating mode. Either way it sets ovf.
  assign ovf_set = tc;

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  assign wrap_nxt = 1'b0;

  always_comb begin
    count_nxt = count;
    if (bus.load) begin
      count_nxt = load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        count_nxt = at_top ? MAX_V : count + 1'b1;
      end else begin
        count_nxt = at_bot ? '0 : count - 1'b1;
      end
    end
  end
`else
  assign wrap_nxt = tc;

  always_comb begin
    count_nxt = count;
    if (bus.load) begin
      count_nxt = load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        count_nxt = at_top ? '0 : count + 1'b1;
      end else begin
        count_nxt = at_bot ? MAX_V : count - 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      count  <= count_nxt;
      wrap_r <= wrap_nxt;
      // set wins over clear on the same edge
      if (ovf_set) begin
        ovf_r <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.out  = count;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: driver pushes model predictions, monitor pops and compares.
module tb_updown_mod_counter;
  localparam int WIDTH = 4;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
  localparam int MAX = 15;
`else
  localparam int MAX = 9;
`endif
  localparam int EW = WIDTH + 3;

  logic clk;
  logic rst;

  updown_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  updown_mod_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  int m_out = 0;
  bit m_ovf = 1'b0;

  // Behavioural model: modular arithmetic over 0..MAX, or clamped arithmetic when saturating.
  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int d, input bit c);
    int  nxt;
    bit  wr;
    bit  set;
    bit  tc_after;
    @(negedge clk);
    rst         = r;
    bus.en      = e;
    bus.up      = u;
    bus.load    = l;
    bus.din     = WIDTH'(d);
    bus.clr_ovf = c;
    wr  = 1'b0;
    set = 1'b0;
    if (r) begin
      m_out = 0;
      m_ovf = 1'b0;
    end else begin
      nxt = m_out;
      if (l) begin
        nxt = (d > MAX) ? MAX : d;
      end else if (e) begin
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        nxt = u ? ((m_out + 1 > MAX) ? MAX : m_out + 1)
                : ((m_out - 1 < 0) ? 0 : m_out - 1);
        set = (nxt == m_out);
`else
        nxt = u ? (m_out + 1) % (MAX + 1) : (m_out + MAX) % (MAX + 1);
        wr  = u ? (nxt < m_out) : (nxt > m_out);
        set = wr;
`endif
      end
      if (set) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      m_out = nxt;
    end
    tc_after = e && !l && (u ? (m_out == MAX) : (m_out == 0));
    exp_q.push_back({WIDTH'(m_out), wr, m_ovf, tc_after});
  endtask

  task automatic check1(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: one prediction per edge, compared just after the edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("out",  int'(bus.out),  int'(e[EW-1:3]));
        check1("wrap", int'(bus.wrap), int'(e[2]));
        check1("ovf",  int'(bus.ovf),  int'(e[1]));
        check1("tc",   int'(bus.tc),   int'(e[0]));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.en = 0; bus.up = 0; bus.load = 0; bus.din = '0; bus.clr_ovf = 0;

    repeat (2) drive(1, 0, 0, 0, 0, 0);
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
    drive(0, 0, 1, 1, 14, 0);
    repeat (3) drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 1, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 0);
`else
    // up count through one wrap
    repeat (12) drive(0, 1, 1, 0, 0, 0);
    // down from 0: wraps to MAX
    drive(0, 1, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 0);
    // clamp and load priority
    drive(0, 0, 1, 1, 13, 0);
    drive(0, 1, 1, 1, 4, 0);
    // sticky clear, then clear coincident with wrap
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 1, 1, 1, 9, 0);
    drive(0, 1, 1, 0, 0, 1);
    // mid-count reset with load
    drive(0, 1, 1, 1, 6, 0);
    drive(1, 1, 1, 1, 3, 0);
    drive(0, 1, 0, 0, 0, 0);
`endif
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
            $urandom_range(0, 2**WIDTH - 1), ($urandom_range(0, 7) == 0));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending predictions", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
